// File: rtl/logic_unit_pipe_pkg.sv
// Shared definitions for the pipelined logic unit.
// Op encodings, op field width and default datapath width.
package logic_unit_pipe_pkg;

    localparam int LOP_W         = 3;
    localparam int DEFAULT_WIDTH = 32;

    localparam logic [LOP_W-1:0] LOP_OR    = 3'd0;
    localparam logic [LOP_W-1:0] LOP_AND   = 3'd1;
    localparam logic [LOP_W-1:0] LOP_XOR   = 3'd2;
    localparam logic [LOP_W-1:0] LOP_NOR   = 3'd3;
    localparam logic [LOP_W-1:0] LOP_ANDN  = 3'd4;
    localparam logic [LOP_W-1:0] LOP_ORN   = 3'd5;
    localparam logic [LOP_W-1:0] LOP_XNOR  = 3'd6;
    localparam logic [LOP_W-1:0] LOP_REDOR = 3'd7;

endpackage

// File: rtl/logic_unit_pipe_op.sv
// Combinational bitwise op block: (op, a, b) -> result.
// Ports: op (3b select), a/b (WIDTH operands), result (WIDTH).
module logic_op_comb
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [LOP_W-1:0] op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        unique case (op)
            LOP_OR:    result = a | b;
            LOP_AND:   result = a & b;
            LOP_XOR:   result = a ^ b;
            LOP_NOR:   result = ~(a | b);
            LOP_ANDN:  result = a & ~b;
            LOP_ORN:   result = a | ~b;
            LOP_XNOR:  result = ~(a ^ b);
            LOP_REDOR: result[0] = |a;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logic unit with valid/ready on both sides.
// Ports: clk, rst_n, in_valid/in_ready/in_op/in_a/in_b,
//        out_valid/out_ready/out_result/out_zero, op_count.
module logic_unit_pipe
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LOP_W-1:0] in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic [CNT_W-1:0] op_count
);

    logic             s1_valid;
    logic [LOP_W-1:0] s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s2_valid;
    logic [WIDTH-1:0] s1_res;

    logic s2_load;
    logic s1_adv;
    logic accept;
    logic handoff;

    // Ready chain flows backward from out_ready only, never from in_valid.
    assign s2_load  = !s2_valid || out_ready;
    assign s1_adv   = s1_valid && s2_load;
    assign in_ready = !s1_valid || s1_adv;
    assign accept   = in_valid && in_ready;
    assign handoff  = s2_valid && out_ready;

    assign out_valid = s2_valid;

    logic_op_comb #(
        .WIDTH(WIDTH)
    ) u_op (
        .op    (s1_op),
        .a     (s1_a),
        .b     (s1_b),
        .result(s1_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= in_op;
            s1_a     <= in_a;
            s1_b     <= in_b;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b1;
        end else if (s1_adv) begin
            s2_valid   <= 1'b1;
            out_result <= s1_res;
            out_zero   <= (s1_res == '0);
        end else if (handoff) begin
            s2_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (handoff && (op_count != '1)) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe.
// Expected results queued on accept, checked on handoff.
module tb_logic_unit_pipe;

    localparam int W  = 32;
    localparam int CW = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_op = '0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_result;
    logic          out_zero;
    logic [CW-1:0] op_count;

    logic_unit_pipe #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_zero  (out_zero),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        int           c;
        bit           lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   model_cnt = 0;
    bit   lat_mode = 1'b0;

    localparam logic [W-1:0] A0 = 32'hF0F0_1234;
    localparam logic [W-1:0] B0 = 32'h0FF0_FFFF;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                      tag, got, exp, $time);
    endtask

    function automatic logic [W-1:0] ref_op(logic [2:0] op,
                                            logic [W-1:0] a,
                                            logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        case (op)
            3'd0: r = a | b;
            3'd1: r = a & b;
            3'd2: r = a ^ b;
            3'd3: r = ~a & ~b;
            3'd4: r = a & ~b;
            3'd5: r = a | ~b;
            3'd6: r = (a & b) | (~a & ~b);
            3'd7: r = (a != 0) ? 1 : 0;
            default: r = '0;
        endcase
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: compare results on handoff, queue expectations on accept.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            check("op_count", op_count, model_cnt);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("result", out_result, e.r);
                    check("zero", out_zero, e.r == 0);
                    if (e.lat) check("latency", cyc, e.c + 2);
                end
                if (model_cnt < CMAX) model_cnt++;
            end
            if (in_valid && in_ready) begin
                e.r   = ref_op(in_op, in_a, in_b);
                e.c   = cyc;
                e.lat = lat_mode;
                sb.push_back(e);
            end
        end
    end

    task automatic issue(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) check("accept_timeout", 1, 0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] held;

    initial begin
        // Reset with in_valid asserted.
        rst_n = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_zero", out_zero, 1);
        check("rst_op_count", op_count, 0);
        check("rst_result", out_result, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Back-to-back streaming, all eight ops.
        lat_mode = 1'b1;
        out_ready = 1'b1;
        for (int op = 0; op < 7; op++) issue(3'(op), A0, B0);
        issue(3'd7, '0, B0);
        issue(3'd7, 32'h8000_0000, '0);
        drain();

        // Back-pressure: two accepted, third refused, head held.
        lat_mode = 1'b0;
        out_ready = 1'b0;
        issue(3'd0, A0, B0);
        issue(3'd2, A0, B0);
        in_valid = 1'b1;
        in_op = 3'd1;
        in_a = A0;
        in_b = B0;
        held = ref_op(3'd0, A0, B0);
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_hold", out_result, held);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(3'd1, A0, B0);
        drain();
        check("bp_empty", out_valid, 0);

        // Asynchronous reset with two ops in flight.
        lat_mode = 1'b1;
        issue(3'd5, A0, B0);
        issue(3'd6, A0, B0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_out_valid", out_valid, 0);
        check("mid_op_count", op_count, 0);
        sb.delete();
        model_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("mid_no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Counter saturation with 20 random ops.
        for (int i = 0; i < 20; i++)
            issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        drain();
        check("sat_count", op_count, CMAX);
        repeat (2) @(posedge clk);
        #1;
        check("sat_hold", op_count, CMAX);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit for the RISC-V datapath; generalises the single 1-bit OR into a WIDTH-bit, 8-operation unit.
- Two register stages with a valid/ready handshake on both sides, so it can sit between decode/issue and writeback under back-pressure.
- Also produces a zero flag and a saturating count of completed operations.

Parameters:
- WIDTH, 32, operand and result width in bits (>= 2)
- CNT_W, 16, width of the completed-operation counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operation valid
- in_ready  out  1  unit can accept an operation this cycle
- in_op  in  3  operation select (encodings below)
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_result  out  WIDTH  operation result
- out_zero  out  1  out_result == 0
- op_count  out  CNT_W  saturating count of results handed off (out_valid & out_ready)

Behaviour:
- Reset: asynchronous on rst_n low. s1_valid, s2_valid, out_valid = 0; out_result = 0; out_zero = 1; op_count = 0. in_ready reads 1 once rst_n is high.
- Reset asserted mid-operation: in-flight operations are discarded; no partial result is ever presented.
- Op encodings:
  - 0 OR: a|b
  - 1 AND: a&b
  - 2 XOR: a^b
  - 3 NOR: ~(a|b)
  - 4 ANDN: a&~b
  - 5 ORN: a|~b
  - 6 XNOR: ~(a^b)
  - 7 REDOR: {WIDTH-1 zeros, |a}; b is ignored.
- Stage 1 (capture):
  - On in_valid & in_ready, register op, a and b; set s1_valid.
- Stage 2 (compute):
  - When s1 advances, register the WIDTH-bit result and zero flag (result == 0); set s2_valid.
  - out_valid = s2_valid; out_result and out_zero come straight from the stage-2 registers.
- Latency: an operation accepted in cycle N appears on the outputs in cycle N+2 when not stalled. Throughput is one operation per cycle.
- Handshake and flow control:
  - s2 can load = !s2_valid | out_ready.
  - s1 advances = s1_valid & (s2 can load).
  - in_ready = !s1_valid | (s1 advances).
  - in_ready must not depend on in_valid (no combinational loop); it is combinational from out_ready.
- Stall: while out_valid & !out_ready, out_result, out_zero and out_valid hold stable. Stage 1 also holds if occupied; the pipeline buffers at most 2 operations.
- Simultaneous events:
  - A handoff and a new capture in the same cycle both take effect.
  - When s2 drains and s1 refills in the same cycle, no bubble is inserted.
- s2 clear: s2_valid clears on handoff only when s1 is not advancing into s2 that cycle.
- op_count: increments on each out_valid & out_ready; saturates at all-ones, never wraps.
- Inputs sampled when in_valid = 0 have no effect. in_op/in_a/in_b are don't-care unless in_valid & in_ready.

Decomposition:
- Shared package: op encoding constants (LOP_OR … LOP_REDOR), op field width 3, default WIDTH.
- One sub-module is natural: logic_op_comb, a purely combinational (op, a, b) -> result block, parametrised on WIDTH. It is reusable by the ALU.
- Pipeline registers, handshake and counter live in logic_unit_pipe.

Test Plan:
- Reset: hold rst_n=0 and drive in_valid=1 -> out_valid=0, out_zero=1, op_count=0. Release -> in_ready=1.
- Streaming, out_ready=1, WIDTH=32: issue back-to-back ops with a=0xF0F0_1234, b=0x0FF0_FFFF.
  - OR -> 0xFFF0_FFFF, 2 cycles after accept.
  - AND -> 0x00F0_1234.
  - XOR -> 0xFF00_EDCB.
  - NOR -> 0x000F_0000.
  - Expect one result per cycle, in order.
- Remaining ops, same operands:
  - ANDN -> 0xF000_0000.
  - ORN -> 0xF0FF_1234.
  - XNOR -> 0x00FF_1234.
  - REDOR with a=0 -> result 0, out_zero=1; REDOR with a=0x8000_0000 -> result 1, out_zero=0.
- Back-pressure:
  - Hold out_ready=0 and issue 3 ops -> first 2 accepted, in_ready=0 on the third, first result held stable.
  - Release out_ready -> all 3 results delivered in order, no loss or duplication.
- Reset mid-flight: 2 ops in the pipe, pulse rst_n low for 1 cycle -> out_valid=0 immediately and asynchronously; no stale result after release; op_count=0.
- Counter saturation: CNT_W=4, complete 20 ops -> op_count reads 15 and stays at 15.
